// File: rtl/packed_word_arbiter_if.sv
// rtl/packed_word_arbiter_if.sv - request/output bundle for packed_word_arbiter
interface packed_word_arbiter_if #(
    parameter int VAL_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [VAL_W-1:0]       req0_val;
    logic                   req0_neg;
    logic [TAG_W-1:0]       req0_tag;
    logic                   req1_valid;
    logic                   req1_ready;
    logic [VAL_W-1:0]       req1_val;
    logic                   req1_neg;
    logic [TAG_W-1:0]       req1_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [VAL_W+TAG_W-1:0] out_word;
    logic                   out_src;
    logic [CNT_W-1:0]       word_cnt;

    modport master (
        output req0_valid, req0_val, req0_neg, req0_tag,
        output req1_valid, req1_val, req1_neg, req1_tag,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_word, out_src, word_cnt
    );

    modport slave (
        input  req0_valid, req0_val, req0_neg, req0_tag,
        input  req1_valid, req1_val, req1_neg, req1_tag,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_word, out_src, word_cnt
    );
endinterface

// File: rtl/packed_word_arbiter.sv
// rtl/packed_word_arbiter.sv - two-way round-robin arbiter onto one {value, tag} word
// Define PACK_NEG_SAT_EN to make negation of the most negative value saturate.
module packed_word_arbiter #(
    parameter int VAL_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    packed_word_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [VAL_W-1:0] VAL_MIN = {1'b1, {(VAL_W-1){1'b0}}};
    localparam logic [VAL_W-1:0] VAL_MAX = {1'b0, {(VAL_W-1){1'b1}}};

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic [VAL_W+TAG_W-1:0] word_q, word_d;
    logic                   src_q, src_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   grant0, grant1;
    logic [VAL_W-1:0]       sel_val, neg_val;
    logic                   sel_neg;
    logic [TAG_W-1:0]       sel_tag;

    always_comb begin
        // ptr_q holds the last grant; requester 0 wins a tie when ptr_q is 1
        grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || ptr_q);
        grant1 = (state_q == IDLE) && bus.req1_valid && !grant0;

        sel_val = grant1 ? bus.req1_val : bus.req0_val;
        sel_neg = grant1 ? bus.req1_neg : bus.req0_neg;
        sel_tag = grant1 ? bus.req1_tag : bus.req0_tag;

        neg_val = {VAL_W{1'b0}} - sel_val;
`ifdef PACK_NEG_SAT_EN
        if (sel_val == VAL_MIN) neg_val = VAL_MAX;
`endif

        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        src_d   = src_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    word_d  = {(sel_neg ? neg_val : sel_val), sel_tag};
                    src_d   = grant1;
                    ptr_d   = grant1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            word_q  <= '0;
            src_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = (state_q == SEND);
    assign bus.out_word   = word_q;
    assign bus.out_src    = src_q;
    assign bus.word_cnt   = cnt_q;
endmodule

// File: tb/tb_packed_word_arbiter.sv
// tb/tb_packed_word_arbiter.sv - scoreboard bench for packed_word_arbiter (CNT_W=4)
module tb_packed_word_arbiter;
    localparam int VAL_W = 8;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    typedef struct {
        logic [11:0] word;
        logic        src;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packed_word_arbiter_if #(.VAL_W(VAL_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    packed_word_arbiter #(.VAL_W(VAL_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    logic       d_v[2];
    logic [7:0] d_val[2];
    logic       d_neg[2];
    logic [3:0] d_tag[2];
    logic       d_rdy;
    logic       pend[2];

    logic       m_send;
    logic       m_ptr;
    int         m_cnt;
    logic       m_just_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pack(input logic [7:0] val, input logic neg, input logic [3:0] tag);
        int v;
        v = int'($signed(val));
        if (neg) begin
            v = -v;
`ifdef PACK_NEG_SAT_EN
            if (v > 127) v = 127;
`endif
        end
        pack = {v[7:0], tag};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_send       = 1'b0;
        m_ptr        = 1'b1;
        m_cnt        = 0;
        m_just_reset = 1'b1;
    endtask

    // one clock of stimulus plus the reference model's view of that cycle
    task automatic step(input logic rst_i, output int granted);
        int   g;
        exp_t e;
        granted = -1;
        @(negedge clk);
        rst            = rst_i;
        bus.req0_valid = d_v[0];
        bus.req0_val   = d_val[0];
        bus.req0_neg   = d_neg[0];
        bus.req0_tag   = d_tag[0];
        bus.req1_valid = d_v[1];
        bus.req1_val   = d_val[1];
        bus.req1_neg   = d_neg[1];
        bus.req1_tag   = d_tag[1];
        bus.out_ready  = d_rdy;
        #1;
        if (rst_i) begin
            model_reset();
            return;
        end
        if (m_just_reset) begin
            chk("reset_out_word", 32'(bus.out_word), 32'h0);
            chk("reset_out_src", 32'(bus.out_src), 32'h0);
            m_just_reset = 1'b0;
        end
        chk("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
        chk("out_valid", 32'(bus.out_valid), 32'(m_send));
        if (!m_send) begin
            g = -1;
            if (d_v[0] && d_v[1]) g = m_ptr ? 0 : 1;
            else if (d_v[0])      g = 0;
            else if (d_v[1])      g = 1;
            chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
            if (g >= 0) begin
                e.word = pack(d_val[g], d_neg[g], d_tag[g]);
                e.src  = g[0];
                exp_q.push_back(e);
                m_ptr   = g[0];
                m_send  = 1'b1;
                granted = g;
            end
        end else begin
            chk("ready_in_send", 32'({bus.req0_ready, bus.req1_ready}), 32'h0);
            if (exp_q.size() > 0) begin
                chk("held_word", 32'(bus.out_word), 32'(exp_q[0].word));
                chk("held_src", 32'(bus.out_src), 32'(exp_q[0].src));
            end
            if (d_rdy) begin
                m_send = 1'b0;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", bus.out_word, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", 32'(bus.out_word), 32'(e.word));
                    chk("out_src", 32'(bus.out_src), 32'(e.src));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [7:0] val,
                           input logic neg, input logic [3:0] tag);
        d_v[i]   = v;
        d_val[i] = val;
        d_neg[i] = neg;
        d_tag[i] = tag;
    endtask

    initial begin : stim
        int g;
        model_reset();
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 8'h0, 1'b0, 4'h0);
        d_rdy   = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        step(1'b1, g);
        step(1'b1, g);
        step(1'b0, g);

        // single negated word
        d_rdy = 1'b1;
        set_req(0, 1'b1, 8'd5, 1'b1, 4'b1010);
        step(1'b0, g);
        set_req(0, 1'b0, 8'd0, 1'b0, 4'h0);
        step(1'b0, g);
        step(1'b0, g);

        // contention from reset alternates 0,1,0,1
        step(1'b1, g);
        set_req(0, 1'b1, 8'h11, 1'b0, 4'h1);
        set_req(1, 1'b1, 8'h22, 1'b0, 4'h2);
        for (int i = 0; i < 10; i++) step(1'b0, g);
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 8'h0, 1'b0, 4'h0);
        step(1'b0, g);
        step(1'b0, g);

        // backpressure
        d_rdy = 1'b0;
        set_req(0, 1'b1, 8'h3C, 1'b0, 4'h5);
        step(1'b0, g);
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        set_req(1, 1'b1, 8'h44, 1'b0, 4'h4);
        for (int i = 0; i < 3; i++) step(1'b0, g);
        d_rdy = 1'b1;
        step(1'b0, g);
        step(1'b0, g);
        set_req(1, 1'b0, 8'h0, 1'b0, 4'h0);
        step(1'b0, g);
        step(1'b0, g);

        // negation edge cases
        set_req(0, 1'b1, 8'h80, 1'b1, 4'h0);
        step(1'b0, g);
        set_req(0, 1'b1, 8'h00, 1'b1, 4'h7);
        step(1'b0, g);
        step(1'b0, g);
        set_req(0, 1'b1, 8'h7F, 1'b1, 4'hF);
        step(1'b0, g);
        step(1'b0, g);
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        step(1'b0, g);
        step(1'b0, g);

        // reset while a word waits in SEND
        d_rdy = 1'b0;
        set_req(1, 1'b1, 8'h99, 1'b1, 4'h3);
        step(1'b0, g);
        step(1'b0, g);
        set_req(0, 1'b1, 8'h11, 1'b0, 4'h1);
        set_req(1, 1'b1, 8'h22, 1'b0, 4'h2);
        step(1'b1, g);
        d_rdy = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, g);
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 8'h0, 1'b0, 4'h0);
        step(1'b0, g);
        step(1'b0, g);

        // counter wrap: 17 words from reset
        step(1'b1, g);
        for (int i = 0; i < 17; i++) begin
            set_req(i % 2, 1'b1, 8'(i * 7), i[2], 4'(i));
            step(1'b0, g);
            set_req(i % 2, 1'b0, 8'h0, 1'b0, 4'h0);
            step(1'b0, g);
        end
        step(1'b0, g);
        chk("word_cnt_wrap", 32'(bus.word_cnt), 32'd1);

        // randomized traffic with hold-until-ready requesters
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    set_req(i, ($urandom_range(0, 9) < 6), 8'($urandom),
                            1'($urandom), 4'($urandom));
                    pend[i] = d_v[i];
                end
            end
            d_rdy = ($urandom_range(0, 9) < 7);
            step(($urandom_range(0, 199) == 0), g);
            if (g >= 0) pend[g] = 1'b0;
        end
        set_req(0, 1'b0, 8'h0, 1'b0, 4'h0);
        set_req(1, 1'b0, 8'h0, 1'b0, 4'h0);
        d_rdy = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, g);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
